// File: rtl/stacker_game_ctrl_if.sv
// Bus between the Stacker game sequencer and its environment (divider, button, row buffer).
interface stacker_game_ctrl_if #(
  parameter int COLS = 8
);
  logic            game_pulse;
  logic            btn;
  logic [3:0]      height;
  logic [COLS-1:0] active_row;
  logic            wr_en;
  logic [3:0]      wr_row;
  logic [COLS-1:0] wr_data;
  logic            game_over;
  logic            game_won;

  modport master (
    output game_pulse, btn,
    input  height, active_row, wr_en, wr_row, wr_data, game_over, game_won
  );

  modport slave (
    input  game_pulse, btn,
    output height, active_row, wr_en, wr_row, wr_data, game_over, game_won
  );
endinterface

// File: rtl/stacker_game_ctrl.sv
// Stacker game sequencer: moves the block, resolves drops against the row below,
// writes placed rows to the display buffer and reports the stack height.
module stacker_game_ctrl #(
  parameter int COLS        = 8,
  parameter int ROWS        = 10,
  parameter int START_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  stacker_game_ctrl_if.slave  bus
);

  localparam int PW = $clog2(COLS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MOVE  = 3'd2,
    S_PLACE = 3'd3,
    S_LOST  = 3'd4,
    S_WON   = 3'd5
  } state_t;

  function automatic logic [COLS-1:0] row_mask(input logic [PW-1:0] p, input logic [4:0] w);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    m = m << p;
    return m[COLS-1:0];
  endfunction

  function automatic logic [4:0] popcount(input logic [COLS-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < COLS; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // Scanning from the top down leaves the lowest set bit as the final winner.
  function automatic logic [PW-1:0] low_idx(input logic [COLS-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = PW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      height_q, height_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [4:0]      width_q, width_d;
  logic            dir_q, dir_d;
  logic [COLS-1:0] prev_row_q, prev_row_d;
  logic [3:0]      clr_idx_q, clr_idx_d;
  logic [COLS-1:0] ov_q, ov_d;
  logic [COLS-1:0] active_row_q, active_row_d;
  logic            wr_en_q, wr_en_d;
  logic [3:0]      wr_row_q, wr_row_d;
  logic [COLS-1:0] wr_data_q, wr_data_d;
  logic            game_over_q, game_over_d;
  logic            game_won_q, game_won_d;
  logic [5:0]      right_end_s;

  assign right_end_s = 6'(pos_q) + 6'(width_q);

  // Next-state and next-output logic for the game sequencer.
  always_comb begin
    state_d    = state_q;
    height_d   = height_q;
    pos_d      = pos_q;
    width_d    = width_q;
    dir_d      = dir_q;
    prev_row_d = prev_row_q;
    clr_idx_d  = clr_idx_q;
    ov_d       = ov_q;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      S_IDLE, S_LOST, S_WON: begin
        if (bus.btn) begin
          state_d   = S_CLEAR;
          clr_idx_d = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_row_d  = clr_idx_q;
        wr_data_d = '0;
        clr_idx_d = clr_idx_q + 4'd1;
        if (clr_idx_q == 4'(ROWS - 1)) begin
          state_d    = S_MOVE;
          height_d   = 4'd0;
          pos_d      = '0;
          width_d    = 5'(START_WIDTH);
          dir_d      = 1'b0;
          prev_row_d = '1;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_MOVE: begin
        // A drop samples the pattern currently shown, so a coincident pulse is discarded.
        if (bus.btn) begin
          ov_d    = active_row_q & prev_row_q;
          state_d = S_PLACE;
        end else if (bus.game_pulse) begin
          if (width_q == 5'(COLS)) begin
            pos_d = '0;
          end else if (!dir_q) begin
            if (right_end_s < 6'(COLS)) begin
              pos_d = pos_q + PW'(1);
            end else begin
              dir_d = 1'b1;
              pos_d = pos_q - PW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = 1'b0;
              pos_d = pos_q + PW'(1);
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
        end else begin
          state_d = S_MOVE;
        end
      end
      S_PLACE: begin
        if (ov_q == '0) begin
          state_d = S_LOST;
        end else begin
          wr_en_d    = 1'b1;
          wr_row_d   = height_q;
          wr_data_d  = ov_q;
          prev_row_d = ov_q;
          width_d    = popcount(ov_q);
          pos_d      = low_idx(ov_q);
          dir_d      = 1'b0;
          if (height_q == 4'(ROWS - 1)) begin
            state_d = S_WON;
          end else begin
            height_d = height_q + 4'd1;
            state_d  = S_MOVE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    active_row_d = row_mask(pos_d, width_d);
    game_over_d  = (state_d == S_LOST);
    game_won_d   = (state_d == S_WON);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      height_q     <= 4'd0;
      pos_q        <= '0;
      width_q      <= 5'(START_WIDTH);
      dir_q        <= 1'b0;
      prev_row_q   <= '1;
      clr_idx_q    <= 4'd0;
      ov_q         <= '0;
      active_row_q <= row_mask('0, 5'(START_WIDTH));
      wr_en_q      <= 1'b0;
      wr_row_q     <= 4'd0;
      wr_data_q    <= '0;
      game_over_q  <= 1'b0;
      game_won_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      height_q     <= height_d;
      pos_q        <= pos_d;
      width_q      <= width_d;
      dir_q        <= dir_d;
      prev_row_q   <= prev_row_d;
      clr_idx_q    <= clr_idx_d;
      ov_q         <= ov_d;
      active_row_q <= active_row_d;
      wr_en_q      <= wr_en_d;
      wr_row_q     <= wr_row_d;
      wr_data_q    <= wr_data_d;
      game_over_q  <= game_over_d;
      game_won_q   <= game_won_d;
    end
  end

  assign bus.height     = height_q;
  assign bus.active_row = active_row_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_row     = wr_row_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.game_over  = game_over_q;
  assign bus.game_won   = game_won_q;

endmodule
